// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester-side and Avalon-side signals of mem_arbiter.
//
// Requester side (3 requesters, 32-bit address/data, flattened 3x32):
//   req_address, req_writedata  96  requester i at bits [32i+31:32i]
//   req_read, req_write          3  per-requester strobes
//   req_readdata                32  Avalon read data broadcast to requesters
//   req_waitrequest              3  per-requester stall
// Avalon master side:
//   avm_address, avm_writedata  32  registered command
//   avm_read, avm_write          1  registered strobes
//   avm_readdata                32  read data from the slave
//   avm_waitrequest              1  slave stall
//
// Modports:
//   slave  - the arbiter's view (requester inputs, Avalon outputs)
//   master - the environment's view (drives requesters and Avalon slave)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic [95:0] req_address;
    logic [95:0] req_writedata;
    logic [2:0]  req_read;
    logic [2:0]  req_write;
    logic [31:0] req_readdata;
    logic [2:0]  req_waitrequest;
    logic [31:0] avm_address;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport slave (
        input  req_address,
        input  req_writedata,
        input  req_read,
        input  req_write,
        output req_readdata,
        output req_waitrequest,
        output avm_address,
        output avm_writedata,
        output avm_read,
        output avm_write,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport master (
        output req_address,
        output req_writedata,
        output req_read,
        output req_write,
        input  req_readdata,
        input  req_waitrequest,
        input  avm_address,
        input  avm_writedata,
        input  avm_read,
        input  avm_write,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates three requesters (0 = instruction register, 1 = program counter,
// 2 = register-file fetch) onto a single Avalon-MM master port. Only one
// Avalon transfer is outstanding at a time; each transfer is followed by one
// IDLE cycle.
//
// Ports:
//   clk     in   main clock
//   rst     in   synchronous active-low reset
//   bus     if   mem_arbiter_if.slave (requester + Avalon signals)
//   grant   out  one-hot owner of the current transfer, 0 when idle
//   cmd_err out  sticky: a winning requester asserted read and write together
//
// Configuration:
//   MEM_ARBITER_ROUND_ROBIN_EN defined   -> round-robin arbitration, search
//                                           starts after the last granted
//                                           requester
//   MEM_ARBITER_ROUND_ROBIN_EN undefined -> fixed priority 0 > 1 > 2
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic [2:0]    grant,
    output logic          cmd_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q,         state_d;
    logic [2:0]  grant_q,         grant_d;
    logic        avm_read_q,      avm_read_d;
    logic        avm_write_q,     avm_write_d;
    logic [31:0] avm_address_q,   avm_address_d;
    logic [31:0] avm_writedata_q, avm_writedata_d;
    logic        cmd_err_q,       cmd_err_d;

    logic [2:0]  req_s;
    logic        win_valid_s;
    logic [1:0]  win_idx_s;
    logic        win_rd_s;
    logic        win_wr_s;
    logic [2:0]  done_mask_s;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic [1:0]  last_grant_q,    last_grant_d;

    // Next requester index after idx, wrapping 2 -> 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] nxt;
        if (idx == 2'd2) begin
            nxt = 2'd0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

    // Round-robin pick: search starts at the requester after 'last'.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] idx0;
        logic [1:0] idx1;
        logic [1:0] idx2;
        logic [1:0] pick;
        idx0 = next_idx(last);
        idx1 = next_idx(idx0);
        idx2 = next_idx(idx1);
        if (req[idx0]) begin
            pick = idx0;
        end else if (req[idx1]) begin
            pick = idx1;
        end else begin
            pick = idx2;
        end
        return pick;
    endfunction
`else
    // Fixed priority pick: lowest index wins.
    function automatic logic [1:0] fixed_pick(input logic [2:0] req);
        logic [1:0] pick;
        if (req[0]) begin
            pick = 2'd0;
        end else if (req[1]) begin
            pick = 2'd1;
        end else begin
            pick = 2'd2;
        end
        return pick;
    endfunction
`endif

    // A requester is active while either of its strobes is high.
    assign req_s       = bus.req_read | bus.req_write;
    assign win_valid_s = |req_s;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    assign win_idx_s = rr_pick(req_s, last_grant_q);
`else
    assign win_idx_s = fixed_pick(req_s);
`endif

    // A simultaneous read+write from the winner is issued as a write only.
    assign win_wr_s = bus.req_write[win_idx_s];
    assign win_rd_s = bus.req_read[win_idx_s] & ~bus.req_write[win_idx_s];

    // Only the owner of a completing transfer is released; a requester that
    // withdrew is not requesting, so its stall is already low.
    assign done_mask_s = ((state_q == ST_BUSY) && !bus.avm_waitrequest) ? grant_q : 3'b000;
    assign bus.req_waitrequest = req_s & ~done_mask_s;
    assign bus.req_readdata    = bus.avm_readdata;

    assign bus.avm_address   = avm_address_q;
    assign bus.avm_writedata = avm_writedata_q;
    assign bus.avm_read      = avm_read_q;
    assign bus.avm_write     = avm_write_q;
    assign grant             = grant_q;
    assign cmd_err           = cmd_err_q;

    // Next-state and command latching for the IDLE/BUSY transfer FSM.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        cmd_err_d       = cmd_err_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_grant_d    = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_d         = ST_BUSY;
                    grant_d         = 3'b001 << win_idx_s;
                    avm_address_d   = bus.req_address[{win_idx_s, 5'b00000} +: 32];
                    avm_writedata_d = bus.req_writedata[{win_idx_s, 5'b00000} +: 32];
                    avm_read_d      = win_rd_s;
                    avm_write_d     = win_wr_s;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    last_grant_d    = win_idx_s;
`endif
                    if (bus.req_read[win_idx_s] && bus.req_write[win_idx_s]) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        cmd_err_d = cmd_err_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Address and writedata deliberately hold after completion.
                if (!bus.avm_waitrequest) begin
                    state_d     = ST_IDLE;
                    grant_d     = 3'b000;
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = 3'b000;
                avm_read_d  = 1'b0;
                avm_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            grant_q         <= 3'b000;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= 32'h0000_0000;
            avm_writedata_q <= 32'h0000_0000;
            cmd_err_q       <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q    <= 2'd2;
`endif
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            cmd_err_q       <= cmd_err_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q    <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Randomised bench for mem_arbiter. A transaction-level reference model in
// the stimulus process predicts each Avalon command and each requester
// completion and pushes them into queues; an independent monitor on the
// falling edge pops and compares whenever the DUT presents a command or
// releases a requester.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] grant;
    logic       cmd_err;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .grant   (grant),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        wr;
    } cmd_t;

    typedef struct {
        logic [2:0]  mask;
        logic [31:0] rdata;
    } comp_t;

    cmd_t  cmd_q[$];
    comp_t comp_q[$];
    logic  exp_err = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit       m_busy  = 1'b0;
    int       m_owner = 0;
    int       m_last  = 2;
    bit       m_err   = 1'b0;
    bit [2:0] done    = 3'b000;

    // Winner from the arbitration rules, -1 when nobody requests.
    function automatic int pick(input bit [2:0] req, input int last);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            if (req[(last + k) % 3]) return (last + k) % 3;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (req[i]) return i;
        end
`endif
        return -1;
    endfunction

    // One clock cycle: model the edge just taken, then drive new inputs and
    // predict what the DUT shows during the coming cycle.
    task automatic cycle(input int p_new, input int p_wait, input int p_wd,
                         input int p_rst, input int p_both);
        bit [2:0] req;
        int       w;
        cmd_t     c;
        comp_t    cp;
        @(posedge clk);
        #1;
        // inputs still hold what the DUT sampled at this edge
        req = bus.req_read | bus.req_write;
        if (!rst) begin
            m_busy = 1'b0;
            m_last = 2;
            m_err  = 1'b0;
        end else if (m_busy) begin
            if (!bus.avm_waitrequest) m_busy = 1'b0;
        end else begin
            w = pick(req, m_last);
            if (w >= 0) begin
                c.owner = w;
                c.addr  = bus.req_address[32*w +: 32];
                c.data  = bus.req_writedata[32*w +: 32];
                c.wr    = bus.req_write[w];
                c.rd    = bus.req_read[w] & ~bus.req_write[w];
                if (bus.req_read[w] && bus.req_write[w]) m_err = 1'b1;
                cmd_q.push_back(c);
                m_busy  = 1'b1;
                m_owner = w;
                m_last  = w;
            end
        end
        exp_err = m_err;

        // requesters: retire completed, occasionally withdraw, issue new
        for (int i = 0; i < 3; i++) begin
            if (done[i] || (($urandom % 100) < p_wd)) begin
                bus.req_read[i]  = 1'b0;
                bus.req_write[i] = 1'b0;
            end
            if (!(bus.req_read[i] || bus.req_write[i]) && (($urandom % 100) < p_new)) begin
                bus.req_address[32*i +: 32]   = $urandom & 32'hFFFF_FFFC;
                bus.req_writedata[32*i +: 32] = $urandom;
                if (($urandom % 100) < p_both) begin
                    bus.req_read[i]  = 1'b1;
                    bus.req_write[i] = 1'b1;
                end else if ($urandom % 2 == 0) begin
                    bus.req_read[i]  = 1'b1;
                end else begin
                    bus.req_write[i] = 1'b1;
                end
            end
        end
        done = 3'b000;
        rst                 = (($urandom % 100) < p_rst) ? 1'b0 : 1'b1;
        bus.avm_waitrequest = (($urandom % 100) < p_wait) ? 1'b1 : 1'b0;
        bus.avm_readdata    = $urandom;

        // a completing transfer releases its owner only if it still requests
        req = bus.req_read | bus.req_write;
        if (m_busy && !bus.avm_waitrequest && req[m_owner]) begin
            done[m_owner] = 1'b1;
            cp.mask  = 3'b001 << m_owner;
            cp.rdata = bus.avm_readdata;
            comp_q.push_back(cp);
        end
    endtask

    // ---------------- monitor ----------------
    cmd_t       cur;
    comp_t      cc;
    logic       prev_strobe  = 1'b0;
    logic       rst_low_prev = 1'b1;
    logic       strobe;
    logic [2:0] rel_mask;

    always @(negedge clk) begin
        strobe = bus.avm_read | bus.avm_write;
        if (rst_low_prev) begin
            cur.owner = 0;
            cur.addr  = 32'h0;
            cur.data  = 32'h0;
            cur.rd    = 1'b0;
            cur.wr    = 1'b0;
        end
        if (strobe && !prev_strobe) begin
            if (cmd_q.size() == 0) begin
                check("unexpected_cmd", {31'd0, strobe}, 32'd0);
            end else begin
                cur = cmd_q.pop_front();
                check("cmd_grant", {29'd0, grant}, 32'd1 << cur.owner);
                check("cmd_addr",  bus.avm_address,   cur.addr);
                check("cmd_data",  bus.avm_writedata, cur.data);
                check("cmd_read",  {31'd0, bus.avm_read},  {31'd0, cur.rd});
                check("cmd_write", {31'd0, bus.avm_write}, {31'd0, cur.wr});
            end
        end else if (strobe) begin
            check("hold_grant", {29'd0, grant}, 32'd1 << cur.owner);
            check("hold_addr",  bus.avm_address,   cur.addr);
            check("hold_data",  bus.avm_writedata, cur.data);
            check("hold_read",  {31'd0, bus.avm_read},  {31'd0, cur.rd});
            check("hold_write", {31'd0, bus.avm_write}, {31'd0, cur.wr});
        end else begin
            if (cmd_q.size() != 0) begin
                check("cmd_missing", {31'd0, strobe}, 32'd1);
                void'(cmd_q.pop_front());
            end
            check("idle_grant", {29'd0, grant}, 32'd0);
            check("idle_addr",  bus.avm_address,   cur.addr);
            check("idle_data",  bus.avm_writedata, cur.data);
        end
        check("cmd_err", {31'd0, cmd_err}, {31'd0, exp_err});

        rel_mask = (bus.req_read | bus.req_write) & ~bus.req_waitrequest;
        if (comp_q.size() != 0) begin
            cc = comp_q.pop_front();
            check("release_mask", {29'd0, rel_mask}, {29'd0, cc.mask});
            check("readdata",     bus.req_readdata,  cc.rdata);
        end else begin
            check("no_release", {29'd0, rel_mask}, 32'd0);
        end
        prev_strobe  = strobe;
        rst_low_prev = ~rst;
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.req_address     = 96'd0;
        bus.req_writedata   = 96'd0;
        bus.req_read        = 3'b000;
        bus.req_write       = 3'b000;
        bus.avm_readdata    = 32'd0;
        bus.avm_waitrequest = 1'b0;
        // reset
        for (int n = 0; n < 3; n++) cycle(0, 0, 0, 100, 0);
        // contention: everyone requests continuously, no wait states
        for (int n = 0; n < 30; n++) cycle(100, 0, 0, 0, 0);
        // contention with wait states and no withdrawal
        for (int n = 0; n < 60; n++) cycle(100, 60, 0, 0, 0);
        // general random traffic: wait states, withdrawal, resets, read+write
        for (int n = 0; n < 3000; n++) cycle(40, 40, 3, 1, 5);
        // drain
        for (int n = 0; n < 12; n++) cycle(0, 0, 100, 0, 0);
        @(negedge clk);
        #1;
        check("cmd_q_drained",  cmd_q.size(),  32'd0);
        check("comp_q_drained", comp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
